seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Parametrised multi-cycle restoring divider for the CPU's MULT/DIV unit.
//   Handles signed and unsigned integer division, selected per operation.
//   Uses a start/busy/done handshake, divide-by-zero flagging and registered results.
//   The control FSM pulses start; quotient and remainder are written to LO and HI.
// PARAMETERS
//   WIDTH     32   operand/result width in bits (>=4)
//   CNT_W     6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      1-cycle request; sampled only when busy=0
//   signed_op  in   1      1 = two's-complement divide, 0 = unsigned
//   dividend   in   WIDTH  numerator, sampled with start
//   divisor    in   WIDTH  denominator, sampled with start
//   quotient   out  WIDTH  registered quotient (goes to LO)
//   remainder  out  WIDTH  registered remainder (goes to HI)
//   busy       out  1      high from the cycle after start until done
//   done       out  1      1-cycle pulse: results valid this cycle
//   div_zero   out  1      sticky with result: last op had divisor==0
// BEHAVIOUR
//   Reset (async): FSM=IDLE; quotient, remainder, busy, done, div_zero, counter all 0.
//   FSM states: IDLE -> RUN -> FIX -> IDLE; ZERO is a 1-cycle alternative path.
//   IDLE, start=1, divisor!=0:
//     - Latch sign flags: sd = signed_op & dividend[MSB], sv = signed_op & divisor[MSB].
//     - Latch magnitudes |dividend| and |divisor|; negation applies only when the flag is set.
//     - Clear partial remainder; counter=WIDTH-1; go to RUN; busy=1.
//   IDLE, start=1, divisor==0: go to ZERO; busy=1.
//   RUN, one quotient bit per clock:
//     - trial = {rem[W-2:0], q[W-1]} - dvs, computed WIDTH+1 bits wide.
//     - If trial is non-negative: rem<=trial, q<={q[W-2:0],1}.
//     - Otherwise: rem<=shifted value, q<={q[W-2:0],0}.
//     - After the counter==0 iteration, go to FIX. RUN lasts exactly WIDTH cycles.
//   FIX, sign correction and output registration:
//     - quotient  <= (sd^sv) ? -q : q.
//     - remainder <= sd ? -rem : rem.
//     - div_zero<=0; done<=1; busy<=0; go to IDLE.
//   ZERO: quotient<={WIDTH{1}}, remainder<=dividend, div_zero<=1, done<=1, busy<=0; go to IDLE.
//   Latency, with start sampled at edge 0:
//     - Normal op: done is high in the cycle after edge WIDTH+1 (34 cycles for WIDTH=32).
//     - Zero divisor: done is high after edge 1.
//   Result semantics:
//     - Division truncates toward zero; remainder takes the dividend's sign.
//     - Always dividend == quotient*divisor + remainder (mod 2**WIDTH).
//   Overflow: signed MIN / -1 gives quotient=MIN, remainder=0, div_zero=0. No trap.
//   Output hold: quotient, remainder and div_zero hold until the next op completes.
//     They do not change during busy. done is exactly one cycle.
//   start while busy=1: ignored; operands are not re-sampled. The in-flight op is unaffected.
//   start in the same cycle as done: accepted, since the FSM is already in IDLE.
//   Back-to-back ops are therefore possible with zero idle cycles.
//   Reset mid-operation: aborts immediately; no done pulse; all outputs return to 0.
//   Unsigned mode: signed_op=0 ignores operand MSBs for sign; full WIDTH-bit unsigned range.
// TESTING
//   T1 unsigned: 100/7, signed_op=0 -> quotient=14, remainder=2, done at cycle 34, busy 33 cycles.
//   T2 signed: -7/2 -> quotient=-3 (0xFFFFFFFD), remainder=-1; 7/-2 -> q=-3, r=1.
//   T3 unsigned 0xFFFFFFFF/2 -> q=0x7FFFFFFF, r=1; the same operands signed -> q=0, r=-1.
//   T4 divide by zero: 55/0 -> done after 2 cycles, div_zero=1, q=0xFFFFFFFF, r=55.
//      Next valid op then clears div_zero.
//   T5 overflow: 0x80000000 / 0xFFFFFFFF signed -> q=0x80000000, r=0, div_zero=0.
//   T6 control:
//     - start pulsed mid-RUN with other operands -> ignored, first result is intact.
//     - reset at cycle 10 -> outputs 0, no done pulse.
//     - start coincident with done -> second result 34 cycles later.
//     - WIDTH=8 instance: 200/3 unsigned -> q=66, r=2 after 10 cycles.

Source files
------------

// File: rtl/seq_divider_if.sv
// Request/response bundle between the MULT/DIV control FSM and the sequential divider.
// The requester drives operands with a start pulse; the divider returns LO/HI results with done.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock on operand magnitudes,
// followed by a sign-fix cycle; divide-by-zero takes a one-cycle shortcut.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     load_op;
  logic                     step_op;
  logic                     fix_op;
  logic                     zero_op;
  logic [CNT_W-1:0]         cnt;
  logic                     sd;
  logic                     sv;
  logic                     sd_in;
  logic                     sv_in;
  logic [WIDTH-1:0]         q;
  logic [WIDTH-1:0]         rem;
  logic [WIDTH-1:0]         dvs;
  logic signed [WIDTH:0]    trial;

  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign sd_in = bus.signed_op & bus.dividend[WIDTH-1];
  assign sv_in = bus.signed_op & bus.divisor[WIDTH-1];

  // Partial remainder never reaches 2**(WIDTH-1) before the last step, so dropping rem's MSB is safe.
  assign trial = $signed({1'b0, rem[WIDTH-2:0], q[WIDTH-1]}) - $signed({1'b0, dvs});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = (bus.divisor == '0) ? ZERO : RUN;
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      ZERO:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_op  = (state == IDLE) && bus.start;
    step_op  = (state == RUN);
    fix_op   = (state == FIX);
    zero_op  = (state == ZERO);
    bus.busy = (state != IDLE);
  end

  // Result stage: outputs only move on completion, so they hold for the whole busy window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
    end else begin
      bus.done <= fix_op | zero_op;
      if (load_op)      cnt <= CNT_W'(WIDTH - 1);
      else if (step_op) cnt <= cnt - CNT_W'(1);
      if (fix_op) begin
        bus.quotient  <= cond_negate(q, sd ^ sv);
        bus.remainder <= cond_negate(rem, sd);
        bus.div_zero  <= 1'b0;
      end else if (zero_op) begin
        bus.quotient  <= '1;
        bus.remainder <= q;
        bus.div_zero  <= 1'b1;
      end
    end
  end

  // Iteration stage: on a zero divisor q carries the raw dividend through to the remainder.
  always_ff @(posedge clk) begin
    if (load_op) begin
      sd  <= sd_in;
      sv  <= sv_in;
      dvs <= cond_negate(bus.divisor, sv_in);
      q   <= (bus.divisor == '0) ? bus.dividend : cond_negate(bus.dividend, sd_in);
      rem <= '0;
    end else if (step_op) begin
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], 1'b1};
      end else begin
        rem <= {rem[WIDTH-2:0], q[WIDTH-1]};
        q   <= {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider at WIDTH=32 and WIDTH=8, with a
// scoreboard per instance compared whenever done pulses.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t sb32[$];
  exp_t sb8[$];
  exp_t m32;
  exp_t m8;
  logic [31:0] last_q;

  seq_divider_if #(.WIDTH(32)) b32();
  seq_divider_if #(.WIDTH(8))  b8();

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  seq_divider #(.WIDTH(8),  .CNT_W(4)) dut8  (.clk(clk), .reset(reset), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                output logic [31:0] q, output logic [31:0] r);
    if (b == 0) begin
      q = '1; r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  always @(negedge clk) begin
    if (b32.done === 1'b1) begin
      if (sb32.size() == 0) check("done32_unexpected", {31'd0, b32.done}, 32'd0);
      else begin
        m32 = sb32.pop_front();
        check({m32.tag, "_q"}, b32.quotient, m32.q);
        check({m32.tag, "_r"}, b32.remainder, m32.r);
        check({m32.tag, "_dz"}, {31'd0, b32.div_zero}, {31'd0, m32.dz});
      end
    end
    if (b8.done === 1'b1) begin
      if (sb8.size() == 0) check("done8_unexpected", {31'd0, b8.done}, 32'd0);
      else begin
        m8 = sb8.pop_front();
        check({m8.tag, "_q"}, {24'd0, b8.quotient}, m8.q);
        check({m8.tag, "_r"}, {24'd0, b8.remainder}, m8.r);
        check({m8.tag, "_dz"}, {31'd0, b8.div_zero}, {31'd0, m8.dz});
      end
    end
  end

  // Drives one op at the current negedge and returns at the negedge where done is seen.
  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b, input bit s,
                      input logic [31:0] eq, input logic [31:0] er, input bit edz, input bit poke);
    int lat;
    int bc;
    int exp_lat;
    b32.start = 1'b1; b32.dividend = a; b32.divisor = b; b32.signed_op = s;
    sb32.push_back('{q: eq, r: er, dz: edz, tag: tag});
    exp_lat = (b == 0) ? 2 : 34;
    @(negedge clk);
    b32.start = 1'b0;
    lat = 1;
    bc  = 0;
    while (b32.done !== 1'b1 && lat < 100) begin
      if (b32.busy === 1'b1) bc++;
      if (poke && lat == 5) begin
        b32.start = 1'b1; b32.dividend = 32'd5; b32.divisor = 32'd1; b32.signed_op = 1'b0;
      end
      if (lat == 6) b32.start = 1'b0;
      if (lat == 10) check({tag, "_hold_q"}, b32.quotient, last_q);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bc, exp_lat - 1);
    last_q = eq;
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input bit s,
                     input logic [7:0] eq, input logic [7:0] er);
    int lat;
    b8.start = 1'b1; b8.dividend = a; b8.divisor = b; b8.signed_op = s;
    sb8.push_back('{q: {24'd0, eq}, r: {24'd0, er}, dz: 1'b0, tag: tag});
    @(negedge clk);
    b8.start = 1'b0;
    lat = 1;
    while (b8.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 10);
  endtask

  task automatic gap();
    @(negedge clk);
    check("done_one_cycle", {31'd0, b32.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rq, rr;
    bit          rs;
    int          seen;
    errors = 0; checks = 0; last_q = 0;
    reset = 1'b1;
    b32.start = 0; b32.signed_op = 0; b32.dividend = 0; b32.divisor = 0;
    b8.start  = 0; b8.signed_op  = 0; b8.dividend  = 0; b8.divisor  = 0;
    repeat (3) @(negedge clk);
    check("rst_q", b32.quotient, 0);
    check("rst_r", b32.remainder, 0);
    check("rst_busy", {31'd0, b32.busy}, 0);
    check("rst_done", {31'd0, b32.done}, 0);
    check("rst_dz", {31'd0, b32.div_zero}, 0);
    reset = 1'b0;
    @(negedge clk);

    op32("t1_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);           gap();
    op32("t2_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0); gap();
    op32("t2_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);       gap();
    op32("t3_unsigned", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);   gap();
    op32("t3_signed", 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);     gap();
    op32("t4_div0", 32'd55, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd55, 1'b1, 1'b0);             gap();
    op32("t4_clear", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);                      gap();
    op32("t5_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b0); gap();
    op32("t6_poke", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b1);                 gap();
    op32("t6_b2b_a", 32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0);
    op32("t6_b2b_b", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0); gap();

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 0) rb = 32'd3;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, rq, rr);
      op32($sformatf("rand%0d", i), ra, rb, rs, rq, rr, 1'b0, 1'b0);
      gap();
    end

    op32("pre_abort_div0", 32'd12, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd12, 1'b1, 1'b0); gap();
    b32.start = 1'b1; b32.dividend = 32'd1234; b32.divisor = 32'd5; b32.signed_op = 1'b0;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_q", b32.quotient, 0);
    check("abort_r", b32.remainder, 0);
    check("abort_busy", {31'd0, b32.busy}, 0);
    check("abort_done", {31'd0, b32.done}, 0);
    check("abort_dz", {31'd0, b32.div_zero}, 0);
    @(negedge clk);
    reset = 1'b0;
    last_q = 0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.done === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);
    op32("after_abort", 32'd77, 32'd7, 1'b0, 32'd11, 32'd0, 1'b0, 1'b0); gap();

    op8("w8_200_3", 8'd200, 8'd3, 1'b0, 8'd66, 8'd2);
    @(negedge clk);
    op8("w8_m100_7", 8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE);
    @(negedge clk);
    op8("w8_ovf", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00);
    @(negedge clk);

    check("sb32_drained", sb32.size(), 0);
    check("sb8_drained", sb8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
